// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS parallel-bus sequencer.
// Includes the state encoding, DDS register map anchors and a byte-select helper.
package dds_pkg;

    typedef enum logic [2:0] {
        MRST,
        INIT_WAIT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        UPDATE
    } dds_state_e;

    localparam logic [5:0] FTW1_BASE    = 6'h04;
    localparam logic [5:0] UPD_CLK_BASE = 6'h16;
    localparam logic [5:0] CTRL_BASE    = 6'h1D;

    localparam int DDS_MAX_BYTES = 6;

    function automatic int cyc_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Byte idx of a len-byte payload, most significant byte first; caller keeps idx < len.
    function automatic logic [7:0] sel_byte(input logic [47:0] data, input logic [2:0] len,
                                            input logic [2:0] idx);
        logic [2:0]  pos;
        logic [47:0] sh;
        pos = len - idx - 3'd1;
        sh  = data >> {pos, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/dds_cyc_timer.sv
// Loadable down-counter with a zero flag; one instance paces every timed state.
// It sits at zero when idle, so a state holds for (load value + 1) clocks.
module dds_cyc_timer #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_bus_sequencer.sv
// DDS parallel programming bus sequencer: master reset, then multi-byte register writes
// with setup/strobe/hold timing and an optional io_ud pulse.
//   state     | meaning
//   MRST      | mst_rst held high after reset release
//   INIT_WAIT | settle time after mst_rst falls
//   IDLE      | ready for a command
//   SETUP     | a/d driven, wrb high before the strobe
//   STROBE    | wrb low
//   HOLD      | wrb high, a/d held; advances to next byte
//   UPDATE    | io_ud high
module dds_bus_sequencer #(
    parameter int MRST_CYC      = 16,
    parameter int INIT_WAIT_CYC = 32,
    parameter int SETUP_CYC     = 2,
    parameter int STROBE_CYC    = 4,
    parameter int HOLD_CYC      = 2,
    parameter int IOUD_CYC      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_addr,
    input  logic [47:0] cmd_data,
    input  logic [2:0]  cmd_len,
    input  logic        cmd_update,
    output logic        mst_rst,
    output logic [7:0]  d,
    output logic [5:0]  a,
    output logic        wrb,
    output logic        io_ud,
    output logic        busy,
    output logic        done
);
    import dds_pkg::*;

    localparam int MAX_CYC = cyc_max(cyc_max(cyc_max(MRST_CYC, INIT_WAIT_CYC),
                                             cyc_max(SETUP_CYC, STROBE_CYC)),
                                     cyc_max(HOLD_CYC, IOUD_CYC));
    localparam int TW = $clog2(MAX_CYC) + 1;

    dds_state_e  state_q, state_d;
    logic [47:0] data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic        upd_q, upd_d;
    logic [5:0]  a_q, a_d;
    logic [7:0]  d_q, d_d;
    logic        wrb_q, wrb_d;
    logic        mst_rst_q, mst_rst_d;
    logic        io_ud_q, io_ud_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  len_eff;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        tmr_zero;

    dds_cyc_timer #(
        .W       (TW),
        .RST_VAL (TW'(MRST_CYC - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        idx_d     = idx_q;
        upd_d     = upd_q;
        a_d       = a_q;
        d_d       = d_q;
        wrb_d     = wrb_q;
        mst_rst_d = mst_rst_q;
        io_ud_d   = io_ud_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        len_eff   = (cmd_len > 3'(DDS_MAX_BYTES)) ? 3'(DDS_MAX_BYTES) : cmd_len;

        unique case (state_q)
            MRST: begin
                if (tmr_zero) begin
                    state_d   = INIT_WAIT;
                    mst_rst_d = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(INIT_WAIT_CYC - 1);
                end
            end
            INIT_WAIT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    data_d = cmd_data;
                    len_d  = len_eff;
                    upd_d  = cmd_update;
                    idx_d  = 3'd0;
                    if (len_eff == 3'd0) begin
                        if (cmd_update) begin
                            state_d  = UPDATE;
                            io_ud_d  = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(IOUD_CYC - 1);
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d  = SETUP;
                        a_d      = cmd_addr;
                        d_d      = sel_byte(cmd_data, len_eff, 3'd0);
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = STROBE;
                    wrb_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(STROBE_CYC - 1);
                end
            end
            STROBE: begin
                if (tmr_zero) begin
                    state_d  = HOLD;
                    wrb_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    // Address wraps naturally in 6 bits (0x3F -> 0x00).
                    a_d   = a_q + 6'd1;
                    idx_d = idx_q + 3'd1;
                    if (idx_d < len_q) begin
                        state_d  = SETUP;
                        d_d      = sel_byte(data_q, len_q, idx_d);
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETUP_CYC - 1);
                    end else if (upd_q) begin
                        state_d  = UPDATE;
                        io_ud_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(IOUD_CYC - 1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            UPDATE: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    io_ud_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = MRST;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MRST;
            data_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            upd_q       <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            wrb_q       <= 1'b1;
            mst_rst_q   <= 1'b1;
            io_ud_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            upd_q       <= upd_d;
            a_q         <= a_d;
            d_q         <= d_d;
            wrb_q       <= wrb_d;
            mst_rst_q   <= mst_rst_d;
            io_ud_q     <= io_ud_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mst_rst   = mst_rst_q;
    assign d         = d_q;
    assign a         = a_q;
    assign wrb       = wrb_q;
    assign io_ud     = io_ud_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
